// File: rtl/pwm_dac.sv
// pwm_dac: sample-rate PWM DAC.
// A free-running period counter requests one filter sample per PWM period
// (start), double-buffers the returned sample through a hold register, and
// drives a registered PWM bitstream whose duty is the offset-binary top
// PWM_BITS bits of the sample.
// Optional sticky overrun/underrun status is built when the macro
// PWM_DAC_STATUS_EN is defined. In that build the clr_status, overrun and
// underrun ports are added. Without it those ports and the flag logic are
// omitted.
module pwm_dac #(
  parameter int PWM_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sig_in,
  input  logic        sig_valid,
`ifdef PWM_DAC_STATUS_EN
  input  logic        clr_status,
`endif
  output logic        start,
  output logic        pwm_out
`ifdef PWM_DAC_STATUS_EN
  ,
  output logic        overrun,
  output logic        underrun
`endif
);

  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = 1;
  localparam logic [PWM_BITS-1:0] MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] active_duty;
  logic [PWM_BITS-1:0] hold;
  logic                hold_valid;
  logic [PWM_BITS-1:0] duty_in;
  logic                at_end;
  logic                unused_lsbs;

  // Truncate to the top PWM_BITS bits and flip the sign bit to get offset binary.
  assign duty_in     = {~sig_in[15], sig_in[14:16-PWM_BITS]};
  assign unused_lsbs = ^sig_in[15-PWM_BITS:0];
  assign at_end      = (cnt == CNT_MAX);

  // start is gated with rst so it is low during reset and high in the very
  // first cycle after release, when cnt is already 0.
  assign start = ~rst & (cnt == '0);

  // Free-running period counter; wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Double buffer: new samples land in hold and move to active_duty at period end.
  // A sample arriving on the transfer cycle still goes to hold, after the old hold moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_duty <= MIDSCALE;
      hold        <= '0;
      hold_valid  <= 1'b0;
    end else begin
      if (at_end && hold_valid) begin
        active_duty <= hold;
      end
      if (sig_valid) begin
        hold       <= duty_in;
        hold_valid <= 1'b1;
      end else if (at_end) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Registered comparator; duty 0 is always low and max duty is high for all but one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < active_duty);
    end
  end

`ifdef PWM_DAC_STATUS_EN
  logic set_overrun;
  logic set_underrun;

  // Overwriting a held sample counts as overrun except on the transfer cycle,
  // where the old hold is consumed first.
  assign set_overrun  = sig_valid & hold_valid & ~at_end;
  assign set_underrun = at_end & ~hold_valid;

  // Sticky flags; a set event in the same cycle as clr_status takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (set_overrun) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
      if (set_underrun) begin
        underrun <= 1'b1;
      end else if (clr_status) begin
        underrun <= 1'b0;
      end
    end
  end
`endif

endmodule
